// File: rtl/atm_pin_entry.sv
`default_nettype none
// ============================================================================
// Module   : atm_pin_entry
// Purpose  : Card/PIN entry front-end with retry limit, idle timeout and lockout.
// Revision : 1.0 - initial release
// ============================================================================
module atm_pin_entry #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_in,
    input  logic [3:0]  card_acc,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        acc_found_stat,
    input  logic        acc_auth_stat,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [2:0]  attempts_left,
    output logic        auth_ok,
    output logic        auth_fail,
    output logic        locked,
    output logic        eject_req,
    output logic        timeout
);

    localparam int                   c_TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]           c_MAX_ATT    = 3'(MAX_ATTEMPTS);
    localparam logic [3:0]           c_KEY_CLEAR  = 4'hA;
    localparam logic [3:0]           c_KEY_ENTER  = 4'hB;
    localparam logic [3:0]           c_KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK_ACC = 3'd1,
        S_ENTER_PIN = 3'd2,
        S_VERIFY    = 3'd3,
        S_GRANTED   = 3'd4,
        S_LOCKED    = 3'd5,
        S_EJECT     = 3'd6
    } state_t;

    state_t               r_state,     w_state_next;
    logic                 r_card_q;
    logic [3:0]           r_acc_num,   w_acc_num_next;
    logic [15:0]          r_pin,       w_pin_next;
    logic [2:0]           r_count,     w_count_next;
    logic [c_TIMER_W-1:0] r_timer,     w_timer_next;
    logic [2:0]           r_attempts,  w_attempts_next;
    logic                 r_auth_ok,   w_auth_ok_next;
    logic                 r_auth_fail, w_auth_fail_next;
    logic                 r_locked,    w_locked_next;
    logic                 r_eject_req, w_eject_req_next;
    logic                 r_timeout,   w_timeout_next;
    logic [2:0]           w_attempts_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_card_q    <= 1'b0;
            r_acc_num   <= 4'd0;
            r_pin       <= 16'd0;
            r_count     <= 3'd0;
            r_timer     <= '0;
            r_attempts  <= c_MAX_ATT;
            r_auth_ok   <= 1'b0;
            r_auth_fail <= 1'b0;
            r_locked    <= 1'b0;
            r_eject_req <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_card_q    <= card_in;
            r_acc_num   <= w_acc_num_next;
            r_pin       <= w_pin_next;
            r_count     <= w_count_next;
            r_timer     <= w_timer_next;
            r_attempts  <= w_attempts_next;
            r_auth_ok   <= w_auth_ok_next;
            r_auth_fail <= w_auth_fail_next;
            r_locked    <= w_locked_next;
            r_eject_req <= w_eject_req_next;
            r_timeout   <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_acc_num_next   = r_acc_num;
        w_pin_next       = r_pin;
        w_count_next     = r_count;
        w_timer_next     = '0;  // timer only advances while waiting for keys
        w_attempts_next  = r_attempts;
        w_auth_ok_next   = r_auth_ok;
        w_auth_fail_next = 1'b0;
        w_locked_next    = r_locked;
        w_eject_req_next = r_eject_req;
        w_timeout_next   = 1'b0;
        w_attempts_dec   = (r_attempts != 3'd0) ? (r_attempts - 3'd1) : 3'd0;

        if ((r_state != S_IDLE) && !card_in) begin
            w_state_next     = S_IDLE;
            w_acc_num_next   = 4'd0;
            w_pin_next       = 16'd0;
            w_count_next     = 3'd0;
            w_attempts_next  = c_MAX_ATT;
            w_auth_ok_next   = 1'b0;
            w_locked_next    = 1'b0;
            w_eject_req_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (card_in && !r_card_q) begin
                        w_state_next    = S_CHECK_ACC;
                        w_acc_num_next  = card_acc;
                        w_attempts_next = c_MAX_ATT;
                        w_pin_next      = 16'd0;
                        w_count_next    = 3'd0;
                    end
                end
                S_CHECK_ACC: begin
                    if ((key_valid && (key_code == c_KEY_CANCEL)) || !acc_found_stat) begin
                        w_state_next     = S_EJECT;
                        w_eject_req_next = 1'b1;
                    end else begin
                        w_state_next = S_ENTER_PIN;
                    end
                end
                S_ENTER_PIN: begin
                    if (key_valid) begin
                        if (key_code == c_KEY_CANCEL) begin
                            w_state_next     = S_EJECT;
                            w_eject_req_next = 1'b1;
                        end else if (key_code <= 4'd9) begin
                            if (r_count < 3'd4) begin
                                w_pin_next   = {r_pin[11:0], key_code};
                                w_count_next = r_count + 3'd1;
                            end
                        end else if (key_code == c_KEY_CLEAR) begin
                            w_pin_next   = 16'd0;
                            w_count_next = 3'd0;
                        end else if ((key_code == c_KEY_ENTER) && (r_count == 3'd4)) begin
                            w_state_next = S_VERIFY;
                        end
                    end else if (r_timer == c_TIMER_LAST) begin
                        w_timeout_next   = 1'b1;
                        w_state_next     = S_EJECT;
                        w_eject_req_next = 1'b1;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
                S_VERIFY: begin
                    if (acc_auth_stat) begin
                        w_state_next   = S_GRANTED;
                        w_auth_ok_next = 1'b1;
                    end else begin
                        w_auth_fail_next = 1'b1;
                        w_attempts_next  = w_attempts_dec;
                        w_pin_next       = 16'd0;
                        w_count_next     = 3'd0;
                        if (w_attempts_dec == 3'd0) begin
                            w_state_next     = S_LOCKED;
                            w_locked_next    = 1'b1;
                            w_eject_req_next = 1'b1;
                        end else begin
                            w_state_next = S_ENTER_PIN;
                        end
                    end
                end
                S_GRANTED, S_LOCKED, S_EJECT: begin
                    w_state_next = r_state;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign acc_num       = r_acc_num;
    assign pin           = r_pin;
    assign attempts_left = r_attempts;
    assign auth_ok       = r_auth_ok;
    assign auth_fail     = r_auth_fail;
    assign locked        = r_locked;
    assign eject_req     = r_eject_req;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_atm_pin_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_pin_entry
// Purpose  : Scoreboard bench for atm_pin_entry with a session-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_pin_entry;

    localparam int         MAX_ATTEMPTS   = 3;
    localparam int         TIMEOUT_CYCLES = 10;
    localparam int         K_OK   = 0;
    localparam int         K_FAIL = 1;
    localparam int         K_LOCK = 2;
    localparam int         K_TMO  = 3;
    localparam int         K_EJ   = 4;
    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        card_in   = 1'b0;
    logic [3:0]  card_acc  = 4'd0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code  = 4'd0;
    logic        acc_found_stat;
    logic        acc_auth_stat;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [2:0]  attempts_left;
    logic        auth_ok;
    logic        auth_fail;
    logic        locked;
    logic        eject_req;
    logic        timeout;

    atm_pin_entry #(
        .MAX_ATTEMPTS   (MAX_ATTEMPTS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .card_in        (card_in),
        .card_acc       (card_acc),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .acc_found_stat (acc_found_stat),
        .acc_auth_stat  (acc_auth_stat),
        .acc_num        (acc_num),
        .pin            (pin),
        .attempts_left  (attempts_left),
        .auth_ok        (auth_ok),
        .auth_fail      (auth_fail),
        .locked         (locked),
        .eject_req      (eject_req),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational authenticator: a tiny account database.
    function automatic logic is_known(input logic [3:0] a);
        return (a == 4'd3) || (a == 4'd5) || (a == 4'd9) || (a == 4'd12);
    endfunction

    function automatic logic [15:0] pin_of(input logic [3:0] a);
        case (a)
            4'd3:    return 16'h1234;
            4'd5:    return 16'h7890;
            4'd9:    return 16'h4321;
            4'd12:   return 16'h0909;
            default: return 16'hFFFF;
        endcase
    endfunction

    assign acc_found_stat = is_known(acc_num);
    assign acc_auth_stat  = is_known(acc_num) && (pin == pin_of(acc_num));

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] pin;
        logic [2:0]  att;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [15:0] pin;
        logic [3:0]  acc;
        logic [2:0]  att;
        logic        ok;
        logic        lk;
        logic        ej;
    } snap_t;

    ev_t   evq[$];
    snap_t snq[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // Session-level model state
    logic [3:0]  m_acc;
    logic [15:0] m_pin;
    int          m_cnt;
    int          m_att;
    logic        m_entry;
    logic        m_ok;
    logic        m_lk;
    logic        m_ej;

    function automatic string kname(input int k);
        case (k)
            K_OK:    return "auth_ok";
            K_FAIL:  return "auth_fail";
            K_LOCK:  return "locked";
            K_TMO:   return "timeout";
            default: return "eject_req";
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_snap(input int c);
        snap_t s;
        s.cyc = c;
        s.pin = m_pin;
        s.acc = m_acc;
        s.att = 3'(m_att);
        s.ok  = m_ok;
        s.lk  = m_lk;
        s.ej  = m_ej;
        snq.push_back(s);
    endtask

    task automatic push_ev(input int kind, input int c, input logic [15:0] p, input int att);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.pin  = p;
        e.att  = 3'(att);
        evq.push_back(e);
    endtask

    task automatic model_clear();
        m_acc   = 4'd0;
        m_pin   = 16'd0;
        m_cnt   = 0;
        m_att   = MAX_ATTEMPTS;
        m_entry = 1'b0;
        m_ok    = 1'b0;
        m_lk    = 1'b0;
        m_ej    = 1'b0;
    endtask

    task automatic insert_card(input logic [3:0] acc);
        int k;
        k        = cyc;
        card_acc = acc;
        card_in  = 1'b1;
        model_clear();
        m_acc = acc;
        push_snap(k + 1);
        if (is_known(acc)) begin
            m_entry = 1'b1;
        end else begin
            m_ej = 1'b1;
            push_ev(K_EJ, k + 2, 16'd0, MAX_ATTEMPTS);
        end
        step();
        step();
    endtask

    task automatic remove_card();
        int k;
        k       = cyc;
        card_in = 1'b0;
        model_clear();
        push_snap(k + 1);
        step();
        step();
    endtask

    // Applies one key strobe; an accepted ENTER also skips the verify cycle.
    task automatic press(input logic [3:0] code);
        int   k;
        logic verify;
        k         = cyc;
        verify    = 1'b0;
        key_valid = 1'b1;
        key_code  = code;
        if (!m_entry) begin
            push_snap(k + 1);
        end else if (code == KEY_CANCEL) begin
            m_ej    = 1'b1;
            m_entry = 1'b0;
            push_snap(k + 1);
            push_ev(K_EJ, k + 1, m_pin, m_att);
        end else if (code <= 4'd9) begin
            if (m_cnt < 4) begin
                m_pin = {m_pin[11:0], code};
                m_cnt++;
            end
            push_snap(k + 1);
        end else if (code == KEY_CLEAR) begin
            m_pin = 16'd0;
            m_cnt = 0;
            push_snap(k + 1);
        end else if ((code == KEY_ENTER) && (m_cnt == 4)) begin
            verify = 1'b1;
            push_snap(k + 1);
            if (m_pin == pin_of(m_acc)) begin
                m_ok    = 1'b1;
                m_entry = 1'b0;
                push_ev(K_OK, k + 2, m_pin, m_att);
            end else begin
                m_att--;
                m_pin = 16'd0;
                m_cnt = 0;
                push_ev(K_FAIL, k + 2, 16'd0, m_att);
                if (m_att == 0) begin
                    m_lk    = 1'b1;
                    m_ej    = 1'b1;
                    m_entry = 1'b0;
                    push_ev(K_LOCK, k + 2, 16'd0, 0);
                end
            end
        end else begin
            push_snap(k + 1);
        end
        step();
        key_valid = 1'b0;
        if (verify) step();
    endtask

    task automatic check_ev(input int kind);
        ev_t  e;
        logic bad;
        n_chk++;
        if (evq.size() == 0) begin
            n_fail++;
            $display("FAIL event@%0d: got unexpected %s, required no event", cyc, kname(kind));
            return;
        end
        e   = evq.pop_front();
        bad = (e.kind != kind) || (e.cyc != cyc);
        if ((kind == K_OK) || (kind == K_FAIL))
            bad = bad || (pin !== e.pin) || (attempts_left !== e.att);
        if ((kind == K_LOCK) || (kind == K_TMO))
            bad = bad || (eject_req !== 1'b1);
        if (kind == K_LOCK)
            bad = bad || (attempts_left !== 3'd0);
        if (bad) begin
            n_fail++;
            $display("FAIL event: got %s at cyc %0d pin=%h att=%0d ej=%b, required %s at cyc %0d pin=%h att=%0d",
                     kname(kind), cyc, pin, attempts_left, eject_req, kname(e.kind), e.cyc, e.pin, e.att);
        end
    endtask

    // Monitor: compares snapshots when due and pops events as the DUT shows them.
    initial begin
        snap_t s;
        logic  ok_q;
        logic  lk_q;
        logic  ej_q;
        ok_q = 1'b0;
        lk_q = 1'b0;
        ej_q = 1'b0;
        forever begin
            @(negedge clk);
            while ((snq.size() > 0) && (snq[0].cyc <= cyc)) begin
                s = snq.pop_front();
                n_chk++;
                if ((s.cyc != cyc) || (pin !== s.pin) || (acc_num !== s.acc) ||
                    (attempts_left !== s.att) || (auth_ok !== s.ok) ||
                    (locked !== s.lk) || (eject_req !== s.ej)) begin
                    n_fail++;
                    $display("FAIL snapshot cyc %0d (due %0d): got pin=%h acc=%0d att=%0d ok=%b lk=%b ej=%b, required pin=%h acc=%0d att=%0d ok=%b lk=%b ej=%b",
                             cyc, s.cyc, pin, acc_num, attempts_left, auth_ok, locked, eject_req,
                             s.pin, s.acc, s.att, s.ok, s.lk, s.ej);
                end
            end
            if (auth_fail === 1'b1) check_ev(K_FAIL);
            if ((auth_ok === 1'b1) && !ok_q) check_ev(K_OK);
            if ((locked === 1'b1) && !lk_q) check_ev(K_LOCK);
            if (timeout === 1'b1) check_ev(K_TMO);
            else if ((eject_req === 1'b1) && !ej_q && (locked !== 1'b1)) check_ev(K_EJ);
            ok_q = (auth_ok === 1'b1);
            lk_q = (locked === 1'b1);
            ej_q = (eject_req === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        int          e;
        logic [3:0]  acc;
        logic [15:0] target;
        logic [3:0]  code;
        int          r;
        int          steps;

        model_clear();
        repeat (3) step();
        rst = 1'b0;
        push_snap(cyc);
        push_snap(cyc + 1);
        step();

        // Normal grant, including a key while granted and removal
        insert_card(4'd3);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER);
        press(4'd7);
        remove_card();

        // Unknown account: keys ignored
        insert_card(4'd7);
        press(4'd1); press(4'd2);
        remove_card();

        // Lockout after three wrong PINs, then a further ENTER
        insert_card(4'd9);
        for (int a = 0; a < 3; a++) begin
            press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(KEY_ENTER);
        end
        press(KEY_ENTER);
        remove_card();

        // Entry editing: CLEAR, premature ENTER, dropped fifth digit
        insert_card(4'd5);
        press(4'd5); press(4'd6); press(KEY_CLEAR); press(4'd7); press(4'd8); press(4'd9);
        press(KEY_ENTER); press(4'd0); press(4'd1); press(KEY_ENTER);
        remove_card();

        // Idle timeout exactly TIMEOUT_CYCLES after entry
        insert_card(4'd3);
        e = cyc;
        push_ev(K_TMO, e + TIMEOUT_CYCLES, 16'd0, MAX_ATTEMPTS);
        m_entry = 1'b0;
        m_ej    = 1'b1;
        repeat (TIMEOUT_CYCLES + 2) step();
        push_snap(cyc);
        remove_card();

        // A key in the expiry cycle postpones the timeout
        insert_card(4'd3);
        e = cyc;
        repeat (TIMEOUT_CYCLES - 1) step();
        press(4'hE);
        push_ev(K_TMO, e + 2 * TIMEOUT_CYCLES, 16'd0, MAX_ATTEMPTS);
        m_entry = 1'b0;
        m_ej    = 1'b1;
        repeat (TIMEOUT_CYCLES + 2) step();
        push_snap(cyc);
        remove_card();

        // Card removal after two digits
        insert_card(4'd12);
        press(4'd3); press(4'd4);
        remove_card();

        // Reset while in VERIFY
        insert_card(4'd3);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        k         = cyc;
        key_valid = 1'b1;
        key_code  = KEY_ENTER;
        push_snap(k + 1);
        step();
        key_valid = 1'b0;
        rst       = 1'b1;
        step();
        rst     = 1'b0;
        card_in = 1'b0;
        model_clear();
        push_snap(cyc);
        step();
        step();

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            case ($urandom_range(0, 4))
                0:       acc = 4'd3;
                1:       acc = 4'd5;
                2:       acc = 4'd9;
                3:       acc = 4'd12;
                default: acc = 4'($urandom_range(13, 15));
            endcase
            insert_card(acc);
            target = 16'd0;
            steps  = 0;
            while (m_entry && (steps < 60)) begin
                if (m_cnt == 0) begin
                    if ($urandom_range(0, 1) == 1) target = pin_of(acc);
                    else target = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end
                r = $urandom_range(0, 99);
                if (r < 3)                                  code = KEY_CANCEL;
                else if (r < 10)                            code = KEY_CLEAR;
                else if (r < 16)                            code = 4'($urandom_range(13, 15));
                else if ((r < 24) || ((m_cnt == 4) && (r < 85))) code = KEY_ENTER;
                else if (m_cnt < 4)                         code = target[15 - 4 * m_cnt -: 4];
                else                                        code = 4'($urandom_range(0, 9));
                press(code);
                repeat ($urandom_range(0, 2)) step();
                steps++;
            end
            if ($urandom_range(0, 1) == 1) press(4'($urandom_range(0, 9)));
            remove_card();
        end

        repeat (3) step();
        n_chk++;
        if ((evq.size() != 0) || (snq.size() != 0)) begin
            n_fail++;
            $display("FAIL leftover: got %0d events and %0d snapshots pending, required 0 and 0",
                     evq.size(), snq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm_pin_entry.md
# atm_pin_entry

Sequential front-end for the ATM authentication stage. It latches the account number from the card reader and collects a 4-digit PIN from the keypad. It drives the combinational authenticator's `acc_num`/`pin` inputs, samples its `acc_found_stat`/`acc_auth_stat` results, and enforces the retry limit, inactivity timeout and card lockout. Its session-granted output feeds the transaction controller downstream.

## Interface
- `MAX_ATTEMPTS`, default 3: wrong-PIN tries allowed per card insertion, range 1–7.
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed in ENTER_PIN before the card is ejected, must be ≥ 2.
- `clk` input, 1 bit: the single clock; everything is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `card_in` input, 1 bit: level, 1 while a card is inserted.
- `card_acc` input, 4 bits: account number from the card, sampled on the `card_in` 0→1 edge.
- `key_valid` input, 1 bit: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` input, 4 bits: 0–9 are digits, 4'hA = CLEAR, 4'hB = ENTER, 4'hC = CANCEL; 4'hD–4'hF are ignored.
- `acc_found_stat` input, 1 bit: from the authenticator, 1 = account found.
- `acc_auth_stat` input, 1 bit: from the authenticator, 1 = PIN authenticated.
- `acc_num` output, 4 bits: registered account number sent to the authenticator.
- `pin` output, 16 bits: registered PIN, 4 BCD digits, first-entered digit in [15:12].
- `attempts_left` output, 3 bits: remaining tries.
- `auth_ok` output, 1 bit: level, session granted.
- `auth_fail` output, 1 bit: one-cycle pulse per rejected PIN.
- `locked` output, 1 bit: level, retries exhausted.
- `eject_req` output, 1 bit: level, asks the user to remove the card.
- `timeout` output, 1 bit: one-cycle pulse when the inactivity timer expires.

## Operation
- States are IDLE, CHECK_ACC, ENTER_PIN, VERIFY, GRANTED, LOCKED and EJECT.
- Reset values:
  - State = IDLE; `acc_num` = 0; `pin` = 0; digit count = 0; timer = 0.
  - `attempts_left` = MAX_ATTEMPTS.
  - All flags and pulses = 0.
- IDLE: on a `card_in` rising edge (registered previous value), latch `card_acc` into `acc_num`, set `attempts_left` = MAX_ATTEMPTS, clear `pin` and the digit count, and go to CHECK_ACC.
- CHECK_ACC: one cycle. If `acc_found_stat` = 1, go to ENTER_PIN. Otherwise go to EJECT with `eject_req` = 1.
- ENTER_PIN:
  - A digit key while count < 4 updates `pin` to {`pin`[11:0], `key_code`} and increments the count.
  - A digit key while count = 4 is dropped.
  - CLEAR sets `pin` = 0 and count = 0.
  - ENTER with count = 4 goes to VERIFY.
  - ENTER with count < 4 is ignored and does not consume an attempt.
  - CANCEL goes to EJECT.
- VERIFY: one cycle; `pin` is already stable at the authenticator.
  - If `acc_auth_stat` = 1, go to GRANTED and set `auth_ok` = 1.
  - Otherwise pulse `auth_fail`, decrement `attempts_left`, clear `pin` and the count.
  - After a failure: if the new `attempts_left` = 0, go to LOCKED with `locked` = 1 and `eject_req` = 1; otherwise return to ENTER_PIN.
- GRANTED: hold `auth_ok` = 1 until `card_in` = 0, then return to IDLE.
- LOCKED: hold `locked` = 1 and `eject_req` = 1 until `card_in` = 0. LOCKED then goes to IDLE; `locked` clears on exit.
- EJECT: hold `eject_req` = 1 until `card_in` = 0, then return to IDLE.
- Card removal: `card_in` = 0 in any non-IDLE state goes to IDLE next cycle. It clears `pin`, `acc_num`, the digit count, `auth_ok`, `eject_req` and `locked`. `attempts_left` is reloaded to MAX_ATTEMPTS.
- Priority, highest first: `rst`, card removal, CANCEL, key processing, timeout.
- `attempts_left` never wraps below 0.

## Timing
- Card edge to CHECK_ACC is 1 cycle; CHECK_ACC to ENTER_PIN is 1 cycle.
- A key strobed in cycle N is reflected in `pin` at cycle N+1.
- ENTER accepted in cycle N gives VERIFY in cycle N+1. The `auth_ok` rise or `auth_fail` pulse appears in cycle N+2.
- Timer:
  - Counts only in ENTER_PIN.
  - Resets to 0 on entry to ENTER_PIN and on every `key_valid` in ENTER_PIN, including ignored codes.
- Timer expiry:
  - When the timer reaches TIMEOUT_CYCLES−1 with no `key_valid` that cycle, the next cycle has `timeout` = 1 for one cycle.
  - In that same cycle the state goes to EJECT with `eject_req` = 1.
  - A key in the expiry cycle wins and resets the timer.
- `key_valid` is ignored outside ENTER_PIN, except CANCEL in CHECK_ACC.
- `rst` asserted mid-session returns all outputs to their reset values on the next edge.

## Test plan
- Normal grant: card 4'd3 (found), keys 1,2,3,4,ENTER with a matching `pin` 16'h1234. Then `auth_ok` = 1 two cycles after ENTER, `attempts_left` = 3, and `auth_ok` drops to 0 the cycle after `card_in` = 0.
- Unknown account: `acc_found_stat` = 0 in CHECK_ACC. Then `eject_req` = 1, and keys are ignored (`pin` stays 0).
- Lockout: three wrong PINs. Expect `auth_fail` pulses with `attempts_left` going 2, 1, 0, then `locked` = 1 and `eject_req` = 1. A fourth ENTER has no effect.
- Entry editing: keys 5,6,CLEAR,7,8,9,0,1,ENTER. Expect `pin` = 16'h7890 at VERIFY (the fifth digit is dropped). An ENTER after only 3 digits is ignored.
- Timeout (TIMEOUT_CYCLES = 10): insert the card and stay idle in ENTER_PIN. Expect the `timeout` pulse exactly 10 cycles after ENTER_PIN entry, then `eject_req` = 1. A key at cycle 9 postpones the timeout.
- Removal/reset mid-entry: after 2 digits, drop `card_in`, which returns to IDLE with `pin` = 0 next cycle. Separately, `rst` during VERIFY leaves all outputs at their reset values.
